// File: rtl/carry_lookahead_adder_r.sv
// Two-level carry-lookahead adder with registered sum and carry-out (one cycle latency).
// Optional registered signed-overflow output V is enabled by defining CLA_OVERFLOW_EN.
module carry_lookahead_adder_r #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef CLA_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  localparam int NG = (WIDTH + GROUP - 1) / GROUP;
  localparam int PW = NG * GROUP;

  // Flat sum-of-products carry into position n: OR_k(g[k] & p[k+1..n-1]) | (p[0..n-1] & ci).
  function automatic logic la_carry(
    input logic [PW-1:0] gv,
    input logic [PW-1:0] pv,
    input logic          ci,
    input int            n
  );
    logic acc_v;
    logic term_v;
    acc_v = ci;
    for (int m = 0; m < PW; m++) begin
      acc_v = acc_v & ((m < n) ? pv[m] : 1'b1);
    end
    for (int k = 0; k < PW; k++) begin
      term_v = gv[k];
      for (int m = 0; m < PW; m++) begin
        term_v = term_v & (((m > k) && (m < n)) ? pv[m] : 1'b1);
      end
      acc_v = acc_v | ((k < n) ? term_v : 1'b0);
    end
    return acc_v;
  endfunction

  logic [PW-1:0]    a_pad_s;
  logic [PW-1:0]    b_pad_s;
  logic [PW-1:0]    g_s;
  logic [PW-1:0]    p_s;
  logic [NG-1:0]    gg_s;
  logic [NG-1:0]    gp_s;
  logic [NG:0]      gc_s;
  logic [PW:0]      c_s;
  logic [WIDTH-1:0] s_next_s;
  logic             cout_next_s;
  logic [WIDTH-1:0] s_r;
  logic             cout_r;

  // Padding bits have g=p=0, so they neither generate nor propagate a carry.
  assign a_pad_s = PW'(A);
  assign b_pad_s = PW'(B);
  assign g_s     = a_pad_s & b_pad_s;
  assign p_s     = a_pad_s ^ b_pad_s;

  for (genvar j = 0; j < NG; j++) begin : g_grp
    assign gg_s[j] = la_carry(PW'(g_s[j*GROUP +: GROUP]), PW'(p_s[j*GROUP +: GROUP]), 1'b0, GROUP);
    assign gp_s[j] = &p_s[j*GROUP +: GROUP];
    for (genvar i = 0; i < GROUP; i++) begin : g_bit
      assign c_s[j*GROUP+i] = la_carry(PW'(g_s[j*GROUP +: GROUP]), PW'(p_s[j*GROUP +: GROUP]),
                                       gc_s[j], i);
    end
  end

  // Second level: carry into each group straight from group G/P and Cin.
  for (genvar j = 0; j <= NG; j++) begin : g_gc
    assign gc_s[j] = la_carry(PW'(gg_s), PW'(gp_s), Cin, j);
  end

  assign c_s[PW]     = gc_s[NG];
  assign s_next_s    = p_s[WIDTH-1:0] ^ c_s[WIDTH-1:0];
  assign cout_next_s = c_s[WIDTH];

  // Result register; reset clears it immediately and drops any in-flight sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_r    <= {WIDTH{1'b0}};
      cout_r <= 1'b0;
    end else begin
      s_r    <= s_next_s;
      cout_r <= cout_next_s;
    end
  end

  assign S    = s_r;
  assign Cout = cout_r;

`ifdef CLA_OVERFLOW_EN
  logic v_next_s;
  logic v_r;

  assign v_next_s = (A[WIDTH-1] == B[WIDTH-1]) && (s_next_s[WIDTH-1] != A[WIDTH-1]);

  // Overflow flag registered alongside the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r <= 1'b0;
    end else begin
      v_r <= v_next_s;
    end
  end

  assign V = v_r;
`endif

endmodule

// File: tb/tb_carry_lookahead_adder_r.sv
// Scoreboard bench for carry_lookahead_adder_r at WIDTH=32, WIDTH=7/GROUP=4 and WIDTH=1.
// Define CLA_OVERFLOW_EN to also check V.
module tb_carry_lookahead_adder_r;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] s;
  logic        cout;
  logic [6:0]  s7;
  logic        cout7;
  logic [0:0]  s1;
  logic        cout1;
`ifdef CLA_OVERFLOW_EN
  logic        v;
  logic        v7;
  logic        v1;
`endif

  always #5 clk = ~clk;

  carry_lookahead_adder_r #(.WIDTH(32), .GROUP(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .Cin(cin), .S(s), .Cout(cout)
`ifdef CLA_OVERFLOW_EN
    , .V(v)
`endif
  );

  carry_lookahead_adder_r #(.WIDTH(7), .GROUP(4)) dut7 (
    .clk(clk), .rst_n(rst_n), .A(a[6:0]), .B(b[6:0]), .Cin(cin), .S(s7), .Cout(cout7)
`ifdef CLA_OVERFLOW_EN
    , .V(v7)
`endif
  );

  carry_lookahead_adder_r #(.WIDTH(1), .GROUP(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .A(a[0:0]), .B(b[0:0]), .Cin(cin), .S(s1), .Cout(cout1)
`ifdef CLA_OVERFLOW_EN
    , .V(v1)
`endif
  );

  typedef struct {
    string       tag;
    logic [32:0] r32;
    logic [7:0]  r7;
    logic [1:0]  r1;
    logic        v32;
    logic        v7;
    logic        v1;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one operand set at negedge; fixed=1 takes the 32-bit result from the caller.
  task automatic drive(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic cv, input logic fixed, input logic [32:0] k, input logic kv);
    exp_t e;
    @(negedge clk);
    a   = av;
    b   = bv;
    cin = cv;
    e.tag = tag;
    e.r32 = fixed ? k : ({1'b0, av} + {1'b0, bv} + {32'd0, cv});
    e.r7  = {1'b0, av[6:0]} + {1'b0, bv[6:0]} + {7'd0, cv};
    e.r1  = {1'b0, av[0]} + {1'b0, bv[0]} + {1'b0, cv};
    e.v32 = fixed ? kv : ((av[31] == bv[31]) && (e.r32[31] != av[31]));
    e.v7  = (av[6] == bv[6]) && (e.r7[6] != av[6]);
    e.v1  = (av[0] == bv[0]) && (e.r1[0] != av[0]);
    sb_q.push_back(e);
  endtask

  // Each entry pushed before a rising edge is compared just after that edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin : pop_blk
      exp_t e;
      e = sb_q.pop_front();
      check_eq({e.tag, "_w32"}, 64'({cout, s}), 64'(e.r32));
      check_eq({e.tag, "_w7"}, 64'({cout7, s7}), 64'(e.r7));
      check_eq({e.tag, "_w1"}, 64'({cout1, s1}), 64'(e.r1));
`ifdef CLA_OVERFLOW_EN
      check_eq({e.tag, "_v32"}, 64'(v), 64'(e.v32));
      check_eq({e.tag, "_v7"}, 64'(v7), 64'(e.v7));
      check_eq({e.tag, "_v1"}, 64'(v1), 64'(e.v1));
`endif
    end
  end

  initial begin
    rst_n = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    cin   = 1'b0;
    #3;
    check_eq("rst_w32", 64'({cout, s}), 64'd0);
    check_eq("rst_w7", 64'({cout7, s7}), 64'd0);
    check_eq("rst_w1", 64'({cout1, s1}), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    drive("t1_a", 32'd1, 32'd1, 1'b0, 1'b1, {1'b0, 32'd2}, 1'b0);
    drive("t1_b", 32'd1, 32'd1, 1'b1, 1'b1, {1'b0, 32'd3}, 1'b0);
    drive("t2_a", 32'd41242, 32'd33, 1'b0, 1'b1, {1'b0, 32'd41275}, 1'b0);
    drive("t2_b", 32'd62523, 32'd0, 1'b0, 1'b1, {1'b0, 32'd62523}, 1'b0);
    drive("t2_c", 32'd3, 32'd32131, 1'b0, 1'b1, {1'b0, 32'd32134}, 1'b0);
    drive("t3_a", 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1, {1'b0, 32'hFFFFFFFF}, 1'b0);
    drive("t3_b", 32'd1, 32'hFFFFFFFF, 1'b0, 1'b1, {1'b1, 32'h00000000}, 1'b0);
    drive("t3_c", 32'd2, 32'hFFFFFFFF, 1'b0, 1'b1, {1'b1, 32'h00000001}, 1'b0);
    drive("wrap", 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, {1'b1, 32'h00000000}, 1'b0);
    drive("ones_cin", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, {1'b1, 32'hFFFFFFFF}, 1'b0);
    drive("t5_a", 32'h7FFFFFFF, 32'd1, 1'b0, 1'b1, {1'b0, 32'h80000000}, 1'b1);
    drive("t5_b", 32'h80000000, 32'h80000000, 1'b0, 1'b1, {1'b1, 32'h00000000}, 1'b1);
    drive("t5_c", 32'd5, 32'd7, 1'b0, 1'b1, {1'b0, 32'd12}, 1'b0);

    // Mid-stream reset: the in-flight operand set is discarded.
    drive("t4_pre", 32'd10, 32'd20, 1'b0, 1'b1, {1'b0, 32'd30}, 1'b0);
    drive("t4_lost", 32'd100, 32'd200, 1'b0, 1'b1, {1'b0, 32'd300}, 1'b0);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check_eq("t4_async_w32", 64'({cout, s}), 64'd0);
    check_eq("t4_async_w7", 64'({cout7, s7}), 64'd0);
`ifdef CLA_OVERFLOW_EN
    check_eq("t4_async_v", 64'(v), 64'd0);
`endif
    @(posedge clk);
    #1;
    check_eq("t4_hold_w32", 64'({cout, s}), 64'd0);
    check_eq("t4_hold_w1", 64'({cout1, s1}), 64'd0);
    #1;
    rst_n = 1'b1;
    drive("t4_post", 32'd7, 32'd8, 1'b0, 1'b1, {1'b0, 32'd15}, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      drive("rnd", 32'($urandom), 32'($urandom), 1'($urandom), 1'b0, 33'd0, 1'b0);
    end

    @(posedge clk);
    #3;
    check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
